atoi_ctl: RTL and testbench

//  Sequencer for the atoi number datapath in the outer interpreter. Takes a token address,

---
 rtl/atoi_ctl_if.sv | 36 +++
 rtl/atoi_ctl.sv | 155 +++++++++++++++
 tb/tb_atoi_ctl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/atoi_ctl_if.sv
// atoi_ctl bus bundle: request/result handshake, shared byte-memory read port and atoi datapath hookup.
// Pure wiring, no logic and no added latency.
// The memory port is stalled by mem_gnt; the master modport is the requester/memory/atoi side, slave is atoi_ctl.
interface atoi_ctl_if #(
  parameter int DSZ = 32,
  parameter int ASZ = 17
);
  logic           req;
  logic           hex;
  logic [ASZ-1:0] ai;
  logic           bsy;
  logic           ack;
  logic [1:0]     ecode;
  logic [DSZ-1:0] vo;
  logic [ASZ-1:0] ao;
  logic           mem_req;
  logic           mem_gnt;
  logic [ASZ-1:0] mem_a;
  logic [7:0]     mem_d;
  logic           atoi_en;
  logic           atoi_hex;
  logic [7:0]     atoi_ch;
  logic           atoi_af;
  logic           atoi_bsy;
  logic [DSZ-1:0] atoi_vo;

  modport master (
    output req, hex, ai, mem_gnt, mem_d, atoi_af, atoi_bsy, atoi_vo,
    input  bsy, ack, ecode, vo, ao, mem_req, mem_a, atoi_en, atoi_hex, atoi_ch
  );

  modport slave (
    input  req, hex, ai, mem_gnt, mem_d, atoi_af, atoi_bsy, atoi_vo,
    output bsy, ack, ecode, vo, ao, mem_req, mem_a, atoi_en, atoi_hex, atoi_ch
  );
endinterface

// File: rtl/atoi_ctl.sv
// Token-to-number sequencer: owns the byte-memory port, steps atoi along its af flag, checks base/terminator, reports value/status/next address.
// Latency: ack 6+s+2n cycles after req with the grant already held (s = leading '-', n = digits); result held until the next ack.
// Waits indefinitely for mem_gnt before fetching; losing the grant mid-token aborts (ecode 3). Optional length cap: ATOI_CTL_MAXLEN_EN.
module atoi_ctl #(
  parameter int DSZ    = 32,
  parameter int ASZ    = 17,
  parameter int MAXLEN = 12
) (
  input  logic      clk,
  input  logic      rst_n,
  atoi_ctl_if.slave bus
);

  // Saturating byte counter; it only has to reach MAXLEN and must never wrap back to 0.
  localparam int CW = $clog2(MAXLEN + 1);

  typedef enum logic [2:0] {IDLE, GNT, FETCH, RUN, DONE} state_t;

  state_t         state, state_n;
  logic [ASZ-1:0] addr;
  logic [CW-1:0]  cnt;
  logic           h;
  logic           dig;
  logic           bad;
  logic           abrt;
  logic           first;
  logic [DSZ-1:0] vo_q;
  logic [ASZ-1:0] ao_q;
  logic [1:0]     ec_q;

  logic           is_dig, is_sign, term_cyc, term_ok, abort, maxhit;
  logic [1:0]     ec_now;
  logic [DSZ-1:0] vo_now;

  assign is_dig   = ((bus.mem_d >= 8'h30) && (bus.mem_d <= 8'h39)) ||
                    (h && (((bus.mem_d >= 8'h61) && (bus.mem_d <= 8'h66)) ||
                           ((bus.mem_d >= 8'h41) && (bus.mem_d <= 8'h46))));
  assign is_sign  = (cnt == '0) && (bus.mem_d == 8'h2d);
  // atoi signals the terminator by dropping bsy on the consuming cycle; its bsy is stale on the first RUN cycle.
  assign term_cyc = (state == RUN) && !first && !bus.atoi_bsy;
  assign term_ok  = (bus.mem_d == 8'h00) || (bus.mem_d == 8'h20);
  assign abort    = ((state == FETCH) || (state == RUN)) && !bus.mem_gnt;

`ifdef ATOI_CTL_MAXLEN_EN
  localparam logic [CW:0] MAXV = MAXLEN[CW:0];
  assign maxhit = (state == RUN) && bus.atoi_af && bus.atoi_bsy && (({1'b0, cnt} + 1'b1) == MAXV);
`else
  assign maxhit = 1'b0;
`endif

  assign ec_now = abrt ? 2'd3 : (!dig ? 2'd1 : (bad ? 2'd2 : 2'd0));
  assign vo_now = (ec_now == 2'd0) ? bus.atoi_vo : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and port outputs; results are live during DONE and held from registers otherwise.
  always_comb begin
    state_n      = state;
    bus.bsy      = (state != IDLE);
    bus.ack      = 1'b0;
    bus.mem_req  = 1'b0;
    bus.atoi_en  = 1'b0;
    bus.mem_a    = addr;
    bus.atoi_hex = h;
    bus.atoi_ch  = bus.mem_d;
    bus.ecode    = ec_q;
    bus.vo       = vo_q;
    bus.ao       = ao_q;
    case (state)
      IDLE:  if (bus.req) state_n = GNT;
      GNT: begin
        bus.mem_req = 1'b1;
        if (bus.mem_gnt) state_n = FETCH;
      end
      FETCH: begin
        bus.mem_req = 1'b1;
        state_n     = abort ? DONE : RUN;
      end
      RUN: begin
        bus.mem_req = 1'b1;
        bus.atoi_en = 1'b1;
        if (abort || term_cyc || maxhit) state_n = DONE;
      end
      DONE: begin
        bus.ack   = 1'b1;
        bus.ecode = ec_now;
        bus.vo    = vo_now;
        bus.ao    = addr;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Token address, character classification flags and held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= '0;
      cnt   <= '0;
      h     <= 1'b0;
      dig   <= 1'b0;
      bad   <= 1'b0;
      abrt  <= 1'b0;
      first <= 1'b0;
      vo_q  <= '0;
      ao_q  <= '0;
      ec_q  <= 2'd0;
    end else begin
      case (state)
        IDLE: if (bus.req) begin
          addr <= bus.ai;
          h    <= bus.hex;
          cnt  <= '0;
          dig  <= 1'b0;
          bad  <= 1'b0;
          abrt <= 1'b0;
        end
        FETCH: begin
          first <= 1'b1;
          if (abort) abrt <= 1'b1;
        end
        RUN: begin
          first <= 1'b0;
          if (abort) begin
            abrt <= 1'b1;
          end else begin
            if (maxhit) abrt <= 1'b1;
            if (bus.atoi_af) begin
              addr <= addr + 1'b1;
              if (cnt != '1) cnt <= cnt + 1'b1;
              if (term_cyc) begin
                if (!term_ok) bad <= 1'b1;
              end else if (is_dig) begin
                dig <= 1'b1;
              end else if (!is_sign) begin
                bad <= 1'b1;
              end
            end
          end
        end
        DONE: begin
          vo_q <= vo_now;
          ao_q <= addr;
          ec_q <= ec_now;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_atoi_ctl.sv
// Bench for atoi_ctl: byte memory, a behavioural atoi datapath and a token-level result model.
// Each conversion is scored cycle by cycle against the model's ack cycle, value, status and next address.
// Grant stall, grant loss, mid-run reset and (macro-dependent) length cap are exercised directly.
module tb_atoi_ctl;
  localparam int DSZ = 32;
  localparam int ASZ = 17;
  localparam int ML  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  atoi_ctl_if #(.DSZ(DSZ), .ASZ(ASZ)) b();
  atoi_ctl #(.DSZ(DSZ), .ASZ(ASZ), .MAXLEN(ML)) dut (.clk(clk), .rst_n(rst_n), .bus(b.slave));

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  logic [7:0] mem [0:1023];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit isdig(input logic [7:0] c, input bit hx);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           (hx && (((c >= 8'h61) && (c <= 8'h66)) || ((c >= 8'h41) && (c <= 8'h46))));
  endfunction

  function automatic logic [31:0] dval(input logic [7:0] c);
    if (c <= 8'h39)      return {24'd0, c - 8'h30};
    else if (c >= 8'h61) return {24'd0, c - 8'h57};
    else                 return {24'd0, c - 8'h37};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Registered read port: data for mem_a appears one cycle later.
  always @(posedge clk) b.mem_d <= mem[b.mem_a[9:0]];

  // atoi datapath: optional sign on its second enabled cycle, then one char every
  // second cycle (fresh data after an advance), dropping bsy on the first non-digit.
  logic [1:0]  at_t   = 2'd0;
  logic        at_paf = 1'b0;
  logic        at_neg = 1'b0;
  logic [31:0] at_acc = 32'd0;

  always_comb begin
    b.atoi_af  = 1'b0;
    b.atoi_bsy = 1'b0;
    if (b.atoi_en) begin
      if (at_t == 2'd1) begin
        b.atoi_af  = (b.atoi_ch == 8'h2d);
        b.atoi_bsy = 1'b1;
      end else if (at_t == 2'd2) begin
        b.atoi_af  = !at_paf;
        b.atoi_bsy = !(!at_paf && !isdig(b.atoi_ch, b.atoi_hex));
      end
    end
  end

  always @(posedge clk) begin
    if (!b.atoi_en) begin
      at_t <= 2'd0; at_paf <= 1'b0; at_neg <= 1'b0; at_acc <= 32'd0;
    end else begin
      if (at_t != 2'd2) at_t <= at_t + 2'd1;
      at_paf <= b.atoi_af;
      if (b.atoi_af) begin
        if (at_t == 2'd1) at_neg <= 1'b1;
        else if (isdig(b.atoi_ch, b.atoi_hex))
          at_acc <= at_acc * (b.atoi_hex ? 32'd16 : 32'd10) + dval(b.atoi_ch);
      end
    end
  end
  assign b.atoi_vo = at_neg ? (~at_acc + 32'd1) : at_acc;

  // Token-level expectation straight from the conversion rules.
  function automatic void model(input logic [16:0] a, input bit hx, input int gd,
                                output int lat, output logic [31:0] v,
                                output logic [1:0] ec, output logic [16:0] ao);
    int s, n;
    logic [16:0] p;
    logic [31:0] val;
    logic [7:0]  c;
    s = 0; n = 0; val = 32'd0; p = a;
    if (mem[p[9:0]] == 8'h2d) begin s = 1; p = p + 17'd1; end
    while (isdig(mem[p[9:0]], hx)) begin
      val = val * (hx ? 32'd16 : 32'd10) + dval(mem[p[9:0]]);
      n++;
      p = p + 17'd1;
    end
    c  = mem[p[9:0]];
    ec = (n == 0) ? 2'd1 : (((c != 8'h00) && (c != 8'h20)) ? 2'd2 : 2'd0);
    v  = (ec != 2'd0) ? 32'd0 : ((s != 0) ? (~val + 32'd1) : val);
    lat = 6 + s + 2 * n + gd;
    ao  = a + 17'(s + n + 1);
`ifdef ATOI_CTL_MAXLEN_EN
    if (s + n >= ML) begin
      ec  = 2'd3;
      v   = 32'd0;
      ao  = a + 17'(ML);
      lat = ((s != 0) ? 4 + 2 * (ML - 1) : 5 + 2 * (ML - 1)) + 1 + gd;
    end
`endif
  endfunction

  // Expectations of the conversion in flight.
  string       tname;
  int          t0      = 0;
  int          exp_lat = 0;
  logic [31:0] exp_vo;
  logic [1:0]  exp_ec;
  logic [16:0] exp_ao;
  bit          active = 1'b0;
  bit          got    = 1'b0;

  // Compare process: every cycle of a conversion, away from the clock edge.
  initial begin : mon
    int rel;
    forever begin
      @(negedge clk);
      #2;
      if (active && rst_n) begin
        rel = cyc - t0;
        if (rel >= 1) begin
          chk({tname, "/ack"}, 64'(b.ack), 64'(rel == exp_lat));
          if (rel < exp_lat) begin
            chk({tname, "/bsy"}, 64'(b.bsy), 64'd1);
            chk({tname, "/mem_req"}, 64'(b.mem_req), 64'd1);
          end
          if (b.ack) begin
            chk({tname, "/ecode"}, 64'(b.ecode), 64'(exp_ec));
            chk({tname, "/vo"}, 64'(b.vo), 64'(exp_vo));
            chk({tname, "/ao"}, 64'(b.ao), 64'(exp_ao));
            got    = 1'b1;
            active = 1'b0;
          end
        end
      end
    end
  end

  task automatic load(input int a, input string s, input logic [7:0] term);
    for (int i = 0; i < s.len(); i++) mem[10'(a + i)] = s[i];
    mem[10'(a + s.len())] = term;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "/ctl"}, 64'({b.bsy, b.ack, b.ecode, b.mem_req, b.atoi_en, b.atoi_hex}), 64'd0);
    chk({nm, "/vo"}, 64'(b.vo), 64'd0);
    chk({nm, "/ao"}, 64'(b.ao), 64'd0);
    chk({nm, "/mem_a"}, 64'(b.mem_a), 64'd0);
  endtask

  // One conversion: gd = grant stall cycles, ab = cycle the grant is dropped, rs = cycle reset is pulsed.
  task automatic conv(input string nm, input logic [16:0] a, input bit hx,
                      input int gd, input int ab, input int rs);
    int lat, rel;
    logic [31:0] v;
    logic [1:0]  ec;
    logic [16:0] ao;
    bit done;
    model(a, hx, gd, lat, v, ec, ao);
    if (ab > 0) begin lat = ab + 1; v = 32'd0; ec = 2'd3; ao = a; end
    @(negedge clk);
    tname = nm; exp_lat = lat; exp_vo = v; exp_ec = ec; exp_ao = ao;
    t0 = cyc; got = 1'b0; active = 1'b1;
    b.req = 1'b1; b.ai = a; b.hex = hx;
    if (gd > 0) b.mem_gnt = 1'b0;
    @(negedge clk);
    b.req = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (gd > 0 && rel == gd + 1) b.mem_gnt = 1'b1;
      if (ab > 0 && rel == ab) b.mem_gnt = 1'b0;
      if (rs > 0 && rel == rs) begin
        rst_n  = 1'b0;
        active = 1'b0;
        #1;
        chk_zero({nm, "/midreset"});
        @(negedge clk);
        rst_n = 1'b1;
        done  = 1'b1;
        got   = 1'b1;
      end else begin
        #3;
        if (got) done = 1'b1;
      end
    end
    b.mem_gnt = 1'b1;
    if (!done) begin
      chk({nm, "/ack_seen"}, 64'(got), 64'd1);
      active = 1'b0;
    end
  endtask

  initial begin : main
    int lat;
    logic [31:0] v;
    logic [1:0]  ec;
    logic [16:0] ao;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    b.req = 1'b0; b.hex = 1'b0; b.ai = '0; b.mem_gnt = 1'b1;
    load(32'h100, "123", 8'h00);
    load(32'h010, "-ff", 8'h20);
    load(32'h200, "1a", 8'h00);
    load(32'h210, "-", 8'h00);
    load(32'h220, "12x", 8'h00);
    load(32'h300, "123456", 8'h00);
    load(32'h320, "FF", 8'h00);

    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_zero("post_reset");

    // Hand-computed pins on the model itself.
    model(17'h100, 1'b0, 0, lat, v, ec, ao);
    chk("pin_dec/lat", 64'(lat), 64'd12);
    chk("pin_dec/vo", 64'(v), 64'd123);
    chk("pin_dec/ao", 64'(ao), 64'h104);
    chk("pin_dec/ec", 64'(ec), 64'd0);
    model(17'h010, 1'b1, 0, lat, v, ec, ao);
    chk("pin_hex/lat", 64'(lat), 64'd11);
    chk("pin_hex/vo", 64'(v), 64'hFFFFFF01);
    chk("pin_hex/ao", 64'(ao), 64'h14);
    model(17'h210, 1'b0, 0, lat, v, ec, ao);
    chk("pin_sign_only/ec", 64'(ec), 64'd1);
    model(17'h300, 1'b0, 0, lat, v, ec, ao);
`ifdef ATOI_CTL_MAXLEN_EN
    chk("pin_long/ec", 64'(ec), 64'd3);
    chk("pin_long/lat", 64'(lat), 64'd12);
`else
    chk("pin_long/vo", 64'(v), 64'd123456);
    chk("pin_long/lat", 64'(lat), 64'd18);
`endif

    conv("dec123",   17'h100, 1'b0, 0, 0, 0);
    conv("hexneg",   17'h010, 1'b1, 0, 0, 0);
    conv("dec1a",    17'h200, 1'b0, 0, 0, 0);
    conv("hex1a",    17'h200, 1'b1, 0, 0, 0);
    conv("signonly", 17'h210, 1'b0, 0, 0, 0);
    conv("dec12x",   17'h220, 1'b0, 0, 0, 0);
    conv("hexFF",    17'h320, 1'b1, 0, 0, 0);
    conv("gntwait",  17'h100, 1'b0, 5, 0, 0);
    conv("gntdrop",  17'h100, 1'b0, 0, 4, 0);
    conv("rstrun",   17'h100, 1'b0, 0, 0, 6);
    conv("afterrst", 17'h010, 1'b1, 0, 0, 0);
    conv("long",     17'h300, 1'b0, 0, 0, 0);
    conv("again",    17'h100, 1'b0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
